mul_pipe: RTL and testbench
===========================

MUL_PIPE -- requirements
Module: mul_pipe

Interface
REQ-001 Parameter XLEN, default 32, operand and result width; legal values 32, 64.
REQ-002 Parameter STAGES, default 3, pipeline depth in cycles; legal range 1..4.
REQ-003 Parameter TAG_W, default 5, width of the opaque tag carried with each operation.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  operation request present.
REQ-007 in_ready  out  1  unit accepts the request this cycle.
REQ-008 rs1, rs2  in  XLEN  source operands.
REQ-009 mul_op  in  2  00=MUL, 01=MULH, 10=MULHSU, 11=MULHU.
REQ-010 in_tag  in  TAG_W  destination tag (rd index), returned unchanged.
REQ-011 flush  in  1  kill all in-flight operations; present only when CARP_MUL_FLUSH_EN is defined.
REQ-012 out_valid  out  1  result present.
REQ-013 out_ready  in  1  consumer accepts the result this cycle.
REQ-014 rd  out  XLEN  result.
REQ-015 out_tag  out  TAG_W  tag of the result.

Function
REQ-016 The unit SHALL accept an operation on any cycle where in_valid and in_ready are both high.
REQ-017 advance = !out_valid || out_ready; in_ready SHALL equal advance, and all stages SHALL shift only when advance is high.
REQ-018 An accepted operation SHALL appear on out_valid exactly STAGES cycles later when no stall occurs; each stall cycle adds one cycle.
REQ-019 Throughput SHALL be one operation per cycle when out_ready is held high.
REQ-020 Each stage SHALL carry a valid bit; bubbles (in_valid low on an advance) SHALL propagate as out_valid low.
REQ-021 rd, out_tag and out_valid SHALL remain stable while out_valid && !out_ready.
REQ-022 Product SHALL be the full 2*XLEN result of rs1 x rs2, with signedness MUL/MULH signed x signed, MULHSU signed rs1 x unsigned rs2, and MULHU unsigned x unsigned.
REQ-023 rd SHALL be product[XLEN-1:0] for MUL and product[2*XLEN-1:XLEN] for the other three ops.
REQ-024 Sign handling SHALL be done as magnitude multiply plus a negate flag applied in the last stage; the most-negative operand SHALL be handled correctly.
REQ-025 mul_op and in_tag SHALL be captured at acceptance and travel with the operation; later input changes SHALL NOT affect it.
REQ-026 Partial-product work SHALL be split across stages so that no stage multiplies more than XLEN x XLEN/2 bits when STAGES >= 2.

Reset
REQ-027 On rst high, all stage valid bits SHALL clear on that edge; out_valid SHALL be 0 and in_ready SHALL be 1 the following cycle.
REQ-028 rd and out_tag SHALL reset to 0; the data registers of the other stages need no reset.
REQ-029 rst asserted mid-operation SHALL discard every in-flight operation, and no result for it SHALL ever appear.
REQ-030 An in_valid presented in a cycle with rst high SHALL NOT be accepted.

Configuration
REQ-031 With CARP_MUL_FLUSH_EN defined, the flush port SHALL exist; flush high SHALL clear all valid bits on that edge, including an accepted same-cycle input; flush SHALL take priority over advance.
REQ-032 Without CARP_MUL_FLUSH_EN, the flush port SHALL be absent and operations SHALL leave only through the output handshake or reset.

Structure
REQ-033 Package carp_mul_pkg SHALL hold the mul_op_e enum (MUL, MULH, MULHSU, MULHU), and the stage-payload struct (valid, op, negate, tag, partial product).
REQ-034 One sub-module, mul_stage, SHALL implement one pipeline register slice with its advance and flush gating, instantiated STAGES times via generate.

Verification
REQ-035 XLEN=32, STAGES=3, out_ready=1: MUL 2x3 -> out_valid 3 cycles later, rd=6, out_tag=in_tag.
REQ-036 MULH 0x80000000 x 0x80000000 -> rd=0x40000000; MULHSU -2 x 3 -> rd=0xFFFFFFFF; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> rd=0xFFFFFFFE.
REQ-037 Four back-to-back MULs with tags 1..4 -> results on four consecutive cycles in order, with no bubbles.
REQ-038 out_ready low for 5 cycles with 3 in flight -> in_ready=0 and rd held stable; after release the results drain in order with none lost or duplicated.
REQ-039 rst pulse while 2 ops are in flight -> no out_valid for them; a new op issued after reset completes in 3 cycles.
REQ-040 CARP_MUL_FLUSH_EN defined: flush with 3 in flight plus a same-cycle accept -> out_valid stays 0 for the next 4 cycles.

Source files
------------

// File: rtl/carp_mul_pkg.sv
// Shared op encoding and pipeline stage payload for mul_pipe.
package carp_mul_pkg;

  localparam int MAX_XLEN  = 64;
  localparam int MAX_TAG_W = 16;
  localparam int PP_W      = 2 * MAX_XLEN;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;

  // Payload sized for the widest configuration; narrower builds use the low bits.
  typedef struct packed {
    logic                 valid;
    mul_op_e              op;
    logic                 negate;
    logic [MAX_TAG_W-1:0] tag;
    logic [MAX_XLEN-1:0]  mag_a;
    logic [MAX_XLEN-1:0]  mag_b;
    logic [PP_W-1:0]      pp;
  } stage_t;

  function automatic logic rs1_signed(input mul_op_e op);
    return op != MULHU;
  endfunction

  function automatic logic rs2_signed(input mul_op_e op);
    return (op == MUL) || (op == MULH);
  endfunction

endpackage

// File: rtl/mul_stage.sv
// One pipeline register slice: valid bit gated by advance/flush, payload loaded on advance.
module mul_stage
  import carp_mul_pkg::*;
#(
  parameter bit RESET_DATA = 1'b0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   advance,
  input  logic   flush,
  input  stage_t d,
  output stage_t q
);

  logic   vld;
  stage_t dat;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld <= 1'b0;
    end else if (advance) begin
      vld <= d.valid;
    end
  end

  // Only the output slice clears its payload so rd/out_tag read zero after reset.
  always_ff @(posedge clk) begin
    if (RESET_DATA && rst) begin
      dat <= '0;
    end else if (advance) begin
      dat <= d;
    end
  end

  always_comb begin
    q       = dat;
    q.valid = vld;
  end

endmodule

// File: rtl/mul_pipe.sv
// Pipelined RISC-V style multiplier (MUL/MULH/MULHSU/MULHU) with valid/ready handshakes.
// Define CARP_MUL_FLUSH_EN to add the flush port that kills all in-flight operations.
module mul_pipe
  import carp_mul_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 3,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [1:0]       mul_op,
  input  logic [TAG_W-1:0] in_tag,
`ifdef CARP_MUL_FLUSH_EN
  input  logic             flush,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  rd,
  output logic [TAG_W-1:0] out_tag
);

  localparam int H  = XLEN / 2;
  localparam int W2 = 2 * XLEN;
  localparam int PW = XLEN + H;

  logic            advance;
  logic            kill;
  mul_op_e         op_in;
  logic            neg1, neg2;
  logic [XLEN-1:0] mag1, mag2;
  stage_t          p_in;
  stage_t          q_all [STAGES];
  stage_t          last;
  logic            unused_last;

`ifdef CARP_MUL_FLUSH_EN
  assign kill = flush;
`else
  assign kill = 1'b0;
`endif

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Signs are stripped up front; the multiplier array only sees magnitudes.
  assign op_in = mul_op_e'(mul_op);
  assign neg1  = rs1_signed(op_in) && rs1[XLEN-1];
  assign neg2  = rs2_signed(op_in) && rs2[XLEN-1];
  assign mag1  = neg1 ? -rs1 : rs1;
  assign mag2  = neg2 ? -rs2 : rs2;

  always_comb begin
    p_in        = '0;
    p_in.valid  = in_valid;
    p_in.op     = op_in;
    p_in.negate = neg1 ^ neg2;
    p_in.tag    = MAX_TAG_W'(in_tag);
    p_in.mag_a  = MAX_XLEN'(mag1);
    p_in.mag_b  = MAX_XLEN'(mag2);
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t          src, nxt;
    logic [XLEN-1:0] a, b;
    logic [W2-1:0]   acc, fin;

    if (k == 0) begin : g_head
      assign src = p_in;
    end else begin : g_body
      assign src = q_all[k-1];
    end

    assign a = src.mag_a[XLEN-1:0];
    assign b = src.mag_b[XLEN-1:0];

    // Stage 0 takes the low half of b, stage 1 the high half; later stages pass through.
    always_comb begin
      acc = src.pp[W2-1:0];
      if (STAGES == 1) begin
        acc = W2'(a) * W2'(b);
      end else if (k == 0) begin
        acc = W2'(PW'(a) * PW'(b[H-1:0]));
      end else if (k == 1) begin
        acc = acc + (W2'(PW'(a) * PW'(b[XLEN-1:H])) << H);
      end
      fin = src.negate ? -acc : acc;
    end

    always_comb begin
      nxt = src;
      if (k == STAGES - 1) begin
        nxt.pp = PP_W'({{XLEN{1'b0}}, (src.op == MUL) ? fin[XLEN-1:0] : fin[W2-1:XLEN]});
      end else begin
        nxt.pp = PP_W'(acc);
      end
    end

    mul_stage #(
      .RESET_DATA(k == STAGES - 1)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .advance (advance),
      .flush   (kill),
      .d       (nxt),
      .q       (q_all[k])
    );
  end

  assign last        = q_all[STAGES-1];
  assign out_valid   = last.valid;
  assign rd          = last.pp[XLEN-1:0];
  assign out_tag     = last.tag[TAG_W-1:0];
  assign unused_last = ^last;

endmodule

// File: tb/tb_mul_pipe.sv
// Self-checking bench for mul_pipe: vector table, scoreboard queue and handshake corner cases.
module tb_mul_pipe;
  localparam int XLEN   = 32;
  localparam int STAGES = 3;
  localparam int TAG_W  = 5;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] rs1, rs2, rd;
  logic [1:0]  mul_op;
  logic [4:0]  in_tag, out_tag;
`ifdef CARP_MUL_FLUSH_EN
  logic        flush;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] rd;
    logic [4:0]  tag;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rd;
  } vec_t;

  exp_t exp_q[$];
  int   pop_cyc[$];
  vec_t vecs[12];
  exp_t mon_e;
  bit   rand_ready = 1'b0;

  mul_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs1       (rs1),
    .rs2       (rs2),
    .mul_op    (mul_op),
    .in_tag    (in_tag),
`ifdef CARP_MUL_FLUSH_EN
    .flush     (flush),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rd        (rd),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'b00, 2'b01: p = sa * sb;
      2'b10:        p = sa * ub;
      default:      p = ua * ub;
    endcase
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Output side: pop expected on every handshake, and hold outputs steady across stalls.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_rd;
  logic [4:0]  prev_tag;
  always @(negedge clk) begin
    if (prev_stall) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_rd", rd, prev_rd);
      check("stall_tag", 32'(out_tag), 32'(prev_tag));
    end
    prev_stall = out_valid && !out_ready && !rst;
    prev_rd    = rd;
    prev_tag   = out_tag;
    if (out_valid && out_ready && !rst) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'(out_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rd", rd, mon_e.rd);
        check("tag", 32'(out_tag), 32'(mon_e.tag));
        pop_cyc.push_back(cyc);
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] exp_rd);
    bit   got = 1'b0;
    exp_t e;
    in_valid = 1'b1;
    mul_op   = op;
    rs1      = a;
    rs2      = b;
    in_tag   = tag;
    for (int n = 0; n < 64 && !got; n++) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        got   = 1'b1;
        e.rd  = exp_rd;
        e.tag = tag;
        exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!got) check("issue_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic latency_mul(input logic [4:0] tag);
    int c0;
    int n = 0;
    c0 = cyc;
    issue(2'b00, 32'd2, 32'd3, tag, 32'd6);
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency_mul", 32'(cyc - c0), 32'd3);
    wait_drain();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    vecs[0]  = '{2'b00, 32'd2,         32'd3,         32'd6};
    vecs[1]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[2]  = '{2'b10, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF};
    vecs[3]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[4]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[5]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[6]  = '{2'b01, 32'h8000_0000, 32'd1,         32'hFFFF_FFFF};
    vecs[7]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[8]  = '{2'b00, 32'h1234_5678, 32'h10,        32'h2345_6780};
    vecs[9]  = '{2'b11, 32'h8000_0000, 32'd2,         32'h0000_0001};
    vecs[10] = '{2'b01, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF};
    vecs[11] = '{2'b00, 32'd0,         32'hDEAD_BEEF, 32'd0};

    // Reset with a request presented: it must not be accepted.
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    mul_op    = 2'b00;
    rs1       = 32'd5;
    rs2       = 32'd7;
    in_tag    = 5'd3;
`ifdef CARP_MUL_FLUSH_EN
    flush     = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_rd", rd, 32'd0);
    check("reset_out_tag", 32'(out_tag), 32'd0);
    repeat (4) begin
      @(negedge clk);
      check("reset_quiet", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    latency_mul(5'd9);

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 10), vecs[i].rd);
    end
    wait_drain();

    // Back-to-back: four results on consecutive cycles.
    pop_cyc.delete();
    for (int t = 1; t <= 4; t++) begin
      issue(2'b00, 32'(t), 32'd10, 5'(t), 32'(t * 10));
    end
    wait_drain();
    check("b2b_count", 32'(pop_cyc.size()), 32'd4);
    if (pop_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++) begin
        check("b2b_gap", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd1);
      end
    end

    // Output stall with the pipe full.
    issue(2'b11, 32'hDEAD_BEEF, 32'h1234_5678, 5'd20, ref_rd(2'b11, 32'hDEAD_BEEF, 32'h1234_5678));
    issue(2'b01, 32'hF000_0001, 32'h0000_0100, 5'd21, ref_rd(2'b01, 32'hF000_0001, 32'h0000_0100));
    issue(2'b00, 32'd1000,      32'd1000,      5'd22, 32'd1000000);
    pop_cyc.delete();
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_drain();
    check("stall_drain_count", 32'(pop_cyc.size()), 32'd3);

    // Reset with two operations in flight.
    issue(2'b00, 32'd7, 32'd8, 5'd25, 32'd56);
    issue(2'b00, 32'd9, 32'd9, 5'd26, 32'd81);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    repeat (6) begin
      @(negedge clk);
      check("post_reset_quiet", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    latency_mul(5'd24);

    // Random traffic with random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom();
      rb  = $urandom();
      if (i % 7 == 0) ra = 32'h8000_0000;
      issue(rop, ra, rb, 5'(i), ref_rd(rop, ra, rb));
      if (i % 5 == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_drain();

`ifdef CARP_MUL_FLUSH_EN
    // Flush with three in flight and a same-cycle accept.
    issue(2'b00, 32'd3, 32'd3, 5'd27, 32'd9);
    issue(2'b00, 32'd4, 32'd4, 5'd28, 32'd16);
    issue(2'b00, 32'd5, 32'd5, 5'd29, 32'd25);
    in_valid = 1'b1;
    mul_op   = 2'b00;
    rs1      = 32'd6;
    rs2      = 32'd6;
    in_tag   = 5'd30;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    repeat (4) begin
      @(negedge clk);
      check("flush_quiet", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    latency_mul(5'd31);
`endif

    wait_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
